// File: rtl/key_note_select.sv
// Piano key front end: sync + debounce 12 keys, pick the lowest pressed one, drive tone-stage compare value.
// Optional release sustain is compiled in with `define SUSTAIN_EN.
module key_note_select #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SUSTAIN_CYCLES  = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] keys_raw,
    output logic        note_valid,
    output logic [3:0]  note_idx,
    output logic [18:0] half_period,
    output logic        note_load
);
    // state | meaning
    // IDLE    | no key selected, tone stage silent
    // PLAY    | a key is selected and sounding
    // SUSTAIN | all keys released, note held until the sustain timer expires
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PLAY    = 2'd1;
`ifdef SUSTAIN_EN
    localparam logic [1:0] SUSTAIN = 2'd2;
    localparam int         SW      = $clog2(SUSTAIN_CYCLES + 1);
    localparam logic [SW-1:0] SUS_LAST = SW'(SUSTAIN_CYCLES - 1);
    logic [SW-1:0] sus_cnt;
`endif

    localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [11:0]   sync1;
    logic [11:0]   sync2;
    logic [11:0]   stable;
    logic [DW-1:0] db_cnt [12];
    logic [1:0]    state;
    logic          sel_valid;
    logic [3:0]    sel;

    function automatic logic [18:0] period_of(input logic [3:0] idx);
        logic [18:0] p;
        case (idx)
            4'd0:    p = 19'd95556;
            4'd1:    p = 19'd90194;
            4'd2:    p = 19'd85131;
            4'd3:    p = 19'd80353;
            4'd4:    p = 19'd75843;
            4'd5:    p = 19'd71586;
            4'd6:    p = 19'd67568;
            4'd7:    p = 19'd63776;
            4'd8:    p = 19'd60197;
            4'd9:    p = 19'd56818;
            4'd10:   p = 19'd53629;
            4'd11:   p = 19'd50619;
            default: p = 19'd0;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
        end
    end

    // Counter only advances on consecutive mismatching cycles; any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < 12; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Scan high to low so the lowest set index is the last assignment.
    always_comb begin
        sel_valid = 1'b0;
        sel       = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (stable[i]) begin
                sel_valid = 1'b1;
                sel       = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            note_valid  <= 1'b0;
            note_idx    <= 4'd0;
            half_period <= 19'd0;
            note_load   <= 1'b0;
`ifdef SUSTAIN_EN
            sus_cnt     <= '0;
`endif
        end else begin
            note_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state       <= PLAY;
                        note_valid  <= 1'b1;
                        note_idx    <= sel;
                        half_period <= period_of(sel);
                        note_load   <= 1'b1;
                    end
                end
                PLAY: begin
                    if (sel_valid) begin
                        if (sel != note_idx) begin
                            note_idx    <= sel;
                            half_period <= period_of(sel);
                            note_load   <= 1'b1;
                        end
                    end else begin
`ifdef SUSTAIN_EN
                        state   <= SUSTAIN;
                        sus_cnt <= '0;
`else
                        state      <= IDLE;
                        note_valid <= 1'b0;
`endif
                    end
                end
`ifdef SUSTAIN_EN
                SUSTAIN: begin
                    if (sel_valid) begin
                        state   <= PLAY;
                        sus_cnt <= '0;
                        if (sel != note_idx) begin
                            note_idx    <= sel;
                            half_period <= period_of(sel);
                            note_load   <= 1'b1;
                        end
                    end else if (sus_cnt == SUS_LAST) begin
                        state      <= IDLE;
                        note_valid <= 1'b0;
                        sus_cnt    <= '0;
                    end else begin
                        sus_cnt <= sus_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    note_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_note_select.sv
// Directed bench for key_note_select with short debounce (4) and sustain (10) timings.
module tb_key_note_select;
    logic        clk;
    logic        rst_n;
    logic [11:0] keys_raw;
    logic        note_valid;
    logic [3:0]  note_idx;
    logic [18:0] half_period;
    logic        note_load;

    int n_cmp = 0;
    int n_bad = 0;

    key_note_select #(.DEBOUNCE_CYCLES(4), .SUSTAIN_CYCLES(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .keys_raw(keys_raw),
        .note_valid(note_valid),
        .note_idx(note_idx),
        .half_period(half_period),
        .note_load(note_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (24) step();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        keys_raw = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({note_valid, note_idx, half_period, note_load} !== 25'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d got v=%b i=%0d hp=%0d ld=%b want all 0",
                         i, note_valid, note_idx, half_period, note_load);
            end
        end
        rst_n = 1'b1;
        repeat (8) step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_idle got v=%b i=%0d hp=%0d ld=%b want all 0",
                     note_valid, note_idx, half_period, note_load);
        end
    endtask

    task automatic test_press();
        keys_raw = 12'h100;
        repeat (6) step();
        n_cmp++;
        if ({note_valid, note_load} !== 2'b00) begin
            n_bad++;
            $display("FAIL press_early got v=%b ld=%b want 0 0", note_valid, note_load);
        end
        step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd8, 19'd60197, 1'b1}) begin
            n_bad++;
            $display("FAIL press_gs got v=%b i=%0d hp=%0d ld=%b want 1 8 60197 1",
                     note_valid, note_idx, half_period, note_load);
        end
        step();
        n_cmp++;
        if ({note_valid, note_load} !== 2'b10) begin
            n_bad++;
            $display("FAIL press_load_width got v=%b ld=%b want 1 0", note_valid, note_load);
        end
        keys_raw = '0;
        settle();
    endtask

    task automatic test_bounce();
        int bad_steps;
        keys_raw = 12'h001;
        repeat (3) step();
        keys_raw = '0;
        bad_steps = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (note_valid !== 1'b0 || note_load !== 1'b0) bad_steps++;
        end
        n_cmp++;
        if (bad_steps !== 0) begin
            n_bad++;
            $display("FAIL bounce_ignored got %0d active cycles want 0", bad_steps);
        end
        keys_raw = 12'h001;
        repeat (6) step();
        n_cmp++;
        if (note_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_hold_early got v=%b want 0", note_valid);
        end
        step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd0, 19'd95556, 1'b1}) begin
            n_bad++;
            $display("FAIL bounce_hold_c got v=%b i=%0d hp=%0d ld=%b want 1 0 95556 1",
                     note_valid, note_idx, half_period, note_load);
        end
        keys_raw = '0;
        settle();
    endtask

    task automatic test_switch();
        int drops;
        int loads;
        keys_raw = 12'h200;
        repeat (7) step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd9, 19'd56818, 1'b1}) begin
            n_bad++;
            $display("FAIL switch_a got v=%b i=%0d hp=%0d ld=%b want 1 9 56818 1",
                     note_valid, note_idx, half_period, note_load);
        end
        keys_raw = 12'h204;
        drops = 0;
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (note_valid !== 1'b1) drops++;
            if (note_load !== 1'b0) loads++;
        end
        n_cmp++;
        if (drops !== 0 || loads !== 0 || note_idx !== 4'd9) begin
            n_bad++;
            $display("FAIL switch_hold got drops=%0d loads=%0d i=%0d want 0 0 9", drops, loads, note_idx);
        end
        step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd2, 19'd85131, 1'b1}) begin
            n_bad++;
            $display("FAIL switch_d got v=%b i=%0d hp=%0d ld=%b want 1 2 85131 1",
                     note_valid, note_idx, half_period, note_load);
        end
        keys_raw = 12'h200;
        drops = 0;
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (note_valid !== 1'b1) drops++;
            if (note_load !== 1'b0) loads++;
        end
        step();
        if (note_valid !== 1'b1) drops++;
        n_cmp++;
        if (drops !== 0 || loads !== 0) begin
            n_bad++;
            $display("FAIL switch_no_gap got drops=%0d extra_loads=%0d want 0 0", drops, loads);
        end
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd9, 19'd56818, 1'b1}) begin
            n_bad++;
            $display("FAIL switch_back_a got v=%b i=%0d hp=%0d ld=%b want 1 9 56818 1",
                     note_valid, note_idx, half_period, note_load);
        end
        keys_raw = '0;
        settle();
    endtask

    task automatic test_simultaneous();
        keys_raw = 12'h088;
        repeat (7) step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd3, 19'd80353, 1'b1}) begin
            n_bad++;
            $display("FAIL simul_low_wins got v=%b i=%0d hp=%0d ld=%b want 1 3 80353 1",
                     note_valid, note_idx, half_period, note_load);
        end
        keys_raw = '0;
        settle();
    endtask

    task automatic test_release();
        keys_raw = 12'h800;
        repeat (7) step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd11, 19'd50619, 1'b1}) begin
            n_bad++;
            $display("FAIL release_b_press got v=%b i=%0d hp=%0d ld=%b want 1 11 50619 1",
                     note_valid, note_idx, half_period, note_load);
        end
        step();
        keys_raw = '0;
`ifdef SUSTAIN_EN
        repeat (16) step();
        n_cmp++;
        if (note_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL release_sustain_hold got v=%b want 1", note_valid);
        end
        step();
        n_cmp++;
        if ({note_valid, note_idx, half_period} !== {1'b0, 4'd11, 19'd50619}) begin
            n_bad++;
            $display("FAIL release_sustain_end got v=%b i=%0d hp=%0d want 0 11 50619",
                     note_valid, note_idx, half_period);
        end
        settle();
        keys_raw = 12'h800;
        repeat (7) step();
        keys_raw = '0;
        repeat (8) step();
        keys_raw = 12'h800;
        begin
            int drops;
            int loads;
            drops = 0;
            loads = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (note_valid !== 1'b1) drops++;
                if (note_load !== 1'b0) loads++;
            end
            n_cmp++;
            if (drops !== 0 || loads !== 0) begin
                n_bad++;
                $display("FAIL sustain_repress got drops=%0d loads=%0d want 0 0", drops, loads);
            end
        end
        keys_raw = '0;
        settle();
`else
        repeat (6) step();
        n_cmp++;
        if (note_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL release_early got v=%b want 1", note_valid);
        end
        step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b0, 4'd11, 19'd50619, 1'b0}) begin
            n_bad++;
            $display("FAIL release_idle got v=%b i=%0d hp=%0d ld=%b want 0 11 50619 0",
                     note_valid, note_idx, half_period, note_load);
        end
        settle();
`endif
    endtask

    task automatic test_reset_mid_note();
        keys_raw = 12'h010;
        repeat (7) step();
        n_cmp++;
        if ({note_valid, note_idx, half_period} !== {1'b1, 4'd4, 19'd75843}) begin
            n_bad++;
            $display("FAIL midrst_e got v=%b i=%0d hp=%0d want 1 4 75843",
                     note_valid, note_idx, half_period);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== 25'd0) begin
            n_bad++;
            $display("FAIL midrst_async got v=%b i=%0d hp=%0d ld=%b want all 0",
                     note_valid, note_idx, half_period, note_load);
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (note_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_redebounce got v=%b want 0", note_valid);
        end
        step();
        n_cmp++;
        if ({note_valid, note_idx, half_period, note_load} !== {1'b1, 4'd4, 19'd75843, 1'b1}) begin
            n_bad++;
            $display("FAIL midrst_return got v=%b i=%0d hp=%0d ld=%b want 1 4 75843 1",
                     note_valid, note_idx, half_period, note_load);
        end
        keys_raw = '0;
        settle();
    endtask

    initial begin
        rst_n    = 1'b0;
        keys_raw = '0;
        test_reset();
        test_press();
        test_bounce();
        test_switch();
        test_simultaneous();
        test_release();
        test_reset_mid_note();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
